// File: rtl/rs_stream_decoder_ctrl.sv
// Single-error RS stream decoder: buffers one N-symbol frame while accumulating
// S1/S2, solves for location/value in one cycle, then replays the corrected frame.
module rs_stream_decoder_ctrl #(
  parameter int N = 7,
  parameter int SYMBOL_WIDTH = 3,
  parameter logic [SYMBOL_WIDTH:0] PRIM_POLY = 4'b1011
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [SYMBOL_WIDTH-1:0] in_symbol,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [SYMBOL_WIDTH-1:0] out_symbol,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    frame_corrected,
  output logic                    frame_uncorrectable,
  output logic                    busy
);

  localparam int SW   = SYMBOL_WIDTH;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int QMAX = (1 << SW) - 1;
  localparam logic [SW-1:0] ALPHA    = SW'(2);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [1:0] {LOAD, SOLVE, EMIT} state_t;

  function automatic logic [SW-1:0] gf_mul(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [SW-1:0] p;
    logic [SW-1:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < SW; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[SW-1] ? ((aa << 1) ^ PRIM_POLY[SW-1:0]) : (aa << 1);
    end
    return p;
  endfunction

  // a^(2^m-2) is the multiplicative inverse; yields 0 for a = 0.
  function automatic logic [SW-1:0] gf_inv(input logic [SW-1:0] a);
    logic [SW-1:0] r;
    r = SW'(1);
    for (int k = 0; k < QMAX - 1; k++) r = gf_mul(r, a);
    return r;
  endfunction

  function automatic logic [SW-1:0] gf_log(input logic [SW-1:0] a);
    logic [SW-1:0] p;
    logic [SW-1:0] l;
    p = SW'(1);
    l = '0;
    for (int k = 0; k < QMAX; k++) begin
      if (p == a) l = k[SW-1:0];
      p = gf_mul(p, ALPHA);
    end
    return l;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [SW-1:0] s1_q, s1_d;
  logic [SW-1:0] s2_q, s2_d;
  logic [SW-1:0] y1_q, y1_d;
  logic [SW-1:0] loc_q, loc_d;
  logic          loc_valid_q, loc_valid_d;
  logic          corr_q, corr_d;
  logic          uncorr_q, uncorr_d;

  logic [SW-1:0] sym_buf [N];
  logic [SW-1:0] err_log;
  logic [SW-1:0] y1_calc;
  logic [SW-1:0] out_j;
  logic          in_accept;
  logic          out_accept;

  assign in_ready   = (state_q == LOAD);
  assign out_valid  = (state_q == EMIT);
  assign in_accept  = in_valid & in_ready;
  assign out_accept = out_valid & out_ready;
  assign busy       = !((state_q == LOAD) && (count_q == '0));

  // Quotients are only consumed when both syndromes are nonzero.
  assign err_log = gf_log(gf_mul(s2_q, gf_inv(s1_q)));
  assign y1_calc = gf_mul(gf_mul(s1_q, s1_q), gf_inv(s2_q));

  assign out_j      = SW'(N - 1) - SW'(idx_q);
  assign out_symbol = out_valid ?
                      (sym_buf[idx_q] ^ ((loc_valid_q && (out_j == loc_q)) ? y1_q : '0)) : '0;
  assign out_last            = out_valid && (idx_q == LAST_IDX);
  assign frame_corrected     = out_valid & corr_q;
  assign frame_uncorrectable = out_valid & uncorr_q;

  always_ff @(posedge clk) begin
    if (in_accept) sym_buf[count_q] <= in_symbol;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    y1_d        = y1_q;
    loc_d       = loc_q;
    loc_valid_d = loc_valid_q;
    corr_d      = corr_q;
    uncorr_d    = uncorr_q;
    case (state_q)
      LOAD: begin
        if (in_accept) begin
          s1_d    = gf_mul(s1_q, ALPHA) ^ in_symbol;
          s2_d    = gf_mul(gf_mul(s2_q, ALPHA), ALPHA) ^ in_symbol;
          count_d = count_q + CW'(1);
          if (count_q == LAST_IDX) state_d = SOLVE;
        end
      end
      SOLVE: begin
        loc_valid_d = 1'b0;
        corr_d      = 1'b0;
        uncorr_d    = 1'b0;
        loc_d       = '0;
        y1_d        = '0;
        if ((s1_q == '0) != (s2_q == '0)) begin
          uncorr_d = 1'b1;
        end else if (s1_q != '0) begin
          if (int'(err_log) >= N) begin
            uncorr_d = 1'b1;
          end else begin
            loc_valid_d = 1'b1;
            corr_d      = 1'b1;
            loc_d       = err_log;
            y1_d        = y1_calc;
          end
        end
        s1_d    = '0;
        s2_d    = '0;
        count_d = '0;
        idx_d   = '0;
        state_d = EMIT;
      end
      EMIT: begin
        if (out_accept) begin
          if (idx_q == LAST_IDX) begin
            idx_d       = '0;
            loc_valid_d = 1'b0;
            corr_d      = 1'b0;
            uncorr_d    = 1'b0;
            state_d     = LOAD;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= LOAD;
      count_q     <= '0;
      idx_q       <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      y1_q        <= '0;
      loc_q       <= '0;
      loc_valid_q <= 1'b0;
      corr_q      <= 1'b0;
      uncorr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      y1_q        <= y1_d;
      loc_q       <= loc_d;
      loc_valid_q <= loc_valid_d;
      corr_q      <= corr_d;
      uncorr_q    <= uncorr_d;
    end
  end

endmodule
